// File: rtl/apb_pkg.sv
// Shared types and decode helpers for the APB wait-state completer.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } apb_state_e;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;
    localparam int CNT_W      = 4;

    // Out-of-range accesses fail in either direction; the top of the map only rejects writes.
    function automatic logic err_addr(input logic [31:0] addr, input logic wr,
                                      input int unsigned depth, input int unsigned roBase);
        return (addr >= depth) || (wr && (addr >= roBase));
    endfunction

endpackage

// File: rtl/apb_slave_regfile.sv
// Word-addressed storage for the APB completer: synchronous write and clear, combinational read.
module apb_slave_regfile #(
    parameter int DEPTH  = 128,
    parameter int DATA_W = 8,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [IDX_W-1:0]  i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Reset is the only way the read-only words ever change, so it clears the whole array.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/apb_wait_slave.sv
// APB completer with a register file and a fixed number of PREADY-low cycles per access.
module apb_wait_slave
    import apb_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int DEPTH       = 128,
    parameter int RO_BASE     = 96,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR
);

    localparam int IDX_W = $clog2(DEPTH);

    apb_state_e        r_state, w_state;
    logic [CNT_W-1:0]  r_cnt, w_cnt;
    logic [ADDR_W-1:0] r_addr, w_addr;
    logic              r_write, w_write;
    logic [DATA_W-1:0] r_wdata, w_wdata;
    logic              r_ready, w_ready;
    logic              r_slverr, w_slverr;
    logic [DATA_W-1:0] r_rdata, w_rdata;
    logic              w_we;
    logic              w_err;
    logic [DATA_W-1:0] w_memRd;

    assign w_err = err_addr(32'(r_addr), r_write, DEPTH, RO_BASE);

    apb_slave_regfile #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_regfile (
        .i_clk   (PCLK),
        .i_reset (PRESET),
        .i_we    (w_we),
        .i_waddr (r_addr[IDX_W-1:0]),
        .i_wdata (r_wdata),
        .i_raddr (r_addr[IDX_W-1:0]),
        .o_rdata (w_memRd)
    );

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_write  <= 1'b0;
            r_wdata  <= '0;
            r_ready  <= 1'b0;
            r_slverr <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_addr   <= w_addr;
            r_write  <= w_write;
            r_wdata  <= w_wdata;
            r_ready  <= w_ready;
            r_slverr <= w_slverr;
            r_rdata  <= w_rdata;
        end
    end

    // PREADY and PSLVERR are one-cycle pulses, so both default low; PRDATA holds between reads.
    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_addr   = r_addr;
        w_write  = r_write;
        w_wdata  = r_wdata;
        w_ready  = 1'b0;
        w_slverr = 1'b0;
        w_rdata  = r_rdata;
        w_we     = 1'b0;

        case (r_state)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    w_addr  = PADDR;
                    w_write = PWRITE;
                    w_wdata = PWDATA;
                    w_cnt   = CNT_W'(WAIT_CYCLES);
                    w_state = ACCESS;
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    w_state = IDLE;
                end else if (r_cnt != '0) begin
                    w_cnt = r_cnt - CNT_W'(1);
                end else begin
                    w_ready = 1'b1;
                    w_state = DONE;
                    if (w_err) begin
                        w_slverr = 1'b1;
                        if (!r_write) begin
                            w_rdata = '0;
                        end
                    end else if (r_write) begin
                        w_we = 1'b1;
                    end else begin
                        w_rdata = w_memRd;
                    end
                end
            end
            DONE: begin
                if (PSEL && !PENABLE) begin
                    w_addr  = PADDR;
                    w_write = PWRITE;
                    w_wdata = PWDATA;
                    w_cnt   = CNT_W'(WAIT_CYCLES);
                    w_state = ACCESS;
                end else begin
                    w_state = IDLE;
                end
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    assign PREADY  = r_ready;
    assign PSLVERR = r_slverr;
    assign PRDATA  = r_rdata;

endmodule

// File: tb/tb_apb_wait_slave.sv
// Scoreboard bench for apb_wait_slave: stimulus queues expected completions, a monitor checks them.
`timescale 1ns/1ps
module tb_apb_wait_slave;

    localparam int WAIT = 2;

    typedef struct {
        logic       wr;
        logic       err;
        logic [7:0] data;
        int         due;
    } exp_t;

    logic       PCLK = 1'b0;
    logic       PRESET = 1'b1;
    logic       PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [7:0] PADDR = '0, PWDATA = '0;
    logic [7:0] PRDATA;
    logic       PREADY, PSLVERR;

    logic       psel0 = 1'b0, penable0 = 1'b0, pwrite0 = 1'b0;
    logic [7:0] paddr0 = '0, pwdata0 = '0;
    logic [7:0] prdata0;
    logic       pready0, pslverr0;

    exp_t sbQ[$];
    int   cycleCnt = 0;
    int   checks = 0;
    int   failures = 0;

    apb_wait_slave #(.WAIT_CYCLES(WAIT)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    apb_wait_slave #(.WAIT_CYCLES(0)) dut0 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel0), .PENABLE(penable0), .PWRITE(pwrite0),
        .PADDR(paddr0), .PWDATA(pwdata0), .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0)
    );

    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h cycle=%0d", name, act, exp, cycleCnt);
        end
    endtask

    // Every PREADY pulse must match the oldest queued expectation, including its arrival cycle.
    always @(posedge PCLK) begin
        exp_t e;
        #1;
        if (PREADY) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpectedReady", 1, 0);
            end else begin
                e = sbQ.pop_front();
                checkOutput("slverr", int'(PSLVERR), int'(e.err));
                checkOutput("readyCycle", cycleCnt, e.due);
                if (!e.wr) checkOutput("rdata", int'(PRDATA), int'(e.data));
            end
        end
    end

    task automatic idle(input int n);
        PSEL = 1'b0;
        PENABLE = 1'b0;
        repeat (n) begin
            @(posedge PCLK);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic [7:0] addr, input logic [7:0] data,
                                 input logic expErr, input logic [7:0] expData);
        exp_t e;
        bit   seen;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data;
        @(posedge PCLK);
        #1;
        e.wr = wr; e.err = expErr; e.data = expData; e.due = cycleCnt + 1 + WAIT;
        sbQ.push_back(e);
        // Bus address/data wander during the access phase; the latched copies must be used.
        PENABLE = 1'b1; PADDR = ~addr; PWDATA = ~data;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge PCLK);
            #1;
            if (PREADY) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checkOutput("readyTimeout", 0, 1);
            void'(sbQ.pop_back());
        end
        PSEL = 1'b0;
        PENABLE = 1'b0;
    endtask

    task automatic applyAbort(input bit useReset);
        int readyCnt;
        readyCnt = 0;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h02; PWDATA = 8'hFF;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        if (PREADY) readyCnt++;
        if (useReset) PRESET = 1'b1;
        else begin PSEL = 1'b0; PENABLE = 1'b0; end
        @(posedge PCLK); #1;
        if (PREADY) readyCnt++;
        if (useReset) begin
            checkOutput("rstAbortReady", int'(PREADY), 0);
            checkOutput("rstAbortSlverr", int'(PSLVERR), 0);
            checkOutput("rstAbortRdata", int'(PRDATA), 0);
        end
        PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        repeat (4) begin
            @(posedge PCLK); #1;
            if (PREADY) readyCnt++;
        end
        checkOutput(useReset ? "rstAbortNoReady" : "pselAbortNoReady", readyCnt, 0);
    endtask

    task automatic applyZeroWait(input logic wr, input logic [7:0] addr, input logic [7:0] data,
                                 input logic [7:0] expData);
        psel0 = 1'b1; penable0 = 1'b0; pwrite0 = wr; paddr0 = addr; pwdata0 = data;
        @(posedge PCLK); #1;
        checkOutput("zwReadyT0", int'(pready0), 0);
        penable0 = 1'b1;
        @(posedge PCLK); #1;
        checkOutput("zwReadyT1", int'(pready0), 1);
        checkOutput("zwSlverr", int'(pslverr0), 0);
        if (!wr) checkOutput("zwRdata", int'(prdata0), int'(expData));
        psel0 = 1'b0; penable0 = 1'b0;
        @(posedge PCLK); #1;
        checkOutput("zwReadyDrop", int'(pready0), 0);
    endtask

    initial begin
        #50000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int readyCnt;
        PRESET = 1'b1;
        repeat (2) @(posedge PCLK);
        #1;
        checkOutput("rstReady", int'(PREADY), 0);
        checkOutput("rstSlverr", int'(PSLVERR), 0);
        checkOutput("rstRdata", int'(PRDATA), 0);
        PRESET = 1'b0;
        idle(1);

        applyStimulus(1'b0, 8'h05, 8'h00, 1'b0, 8'h00); idle(1);
        applyStimulus(1'b1, 8'h10, 8'hA5, 1'b0, 8'h00); idle(1);
        applyStimulus(1'b0, 8'h10, 8'h00, 1'b0, 8'hA5); idle(1);
        applyStimulus(1'b1, 8'h60, 8'h3C, 1'b1, 8'h00); idle(1);
        applyStimulus(1'b0, 8'h60, 8'h00, 1'b0, 8'h00); idle(1);
        applyStimulus(1'b0, 8'h10, 8'h00, 1'b0, 8'hA5); idle(1);
        applyStimulus(1'b0, 8'h80, 8'h00, 1'b1, 8'h00); idle(1);
        applyStimulus(1'b1, 8'h5F, 8'h5A, 1'b0, 8'h00); idle(1);
        applyStimulus(1'b0, 8'h5F, 8'h00, 1'b0, 8'h5A); idle(1);
        applyStimulus(1'b0, 8'h7F, 8'h00, 1'b0, 8'h00); idle(1);
        applyStimulus(1'b1, 8'h7F, 8'h01, 1'b1, 8'h00); idle(1);

        // Back-to-back: the read's setup is driven during the write's DONE cycle.
        applyStimulus(1'b1, 8'h01, 8'h11, 1'b0, 8'h00);
        applyStimulus(1'b0, 8'h01, 8'h00, 1'b0, 8'h11); idle(1);

        applyAbort(1'b0);
        applyStimulus(1'b0, 8'h02, 8'h00, 1'b0, 8'h00); idle(1);
        applyStimulus(1'b0, 8'h10, 8'h00, 1'b0, 8'hA5); idle(1);
        applyAbort(1'b1);
        applyStimulus(1'b0, 8'h02, 8'h00, 1'b0, 8'h00); idle(1);
        applyStimulus(1'b0, 8'h10, 8'h00, 1'b0, 8'h00); idle(1);

        readyCnt = 0;
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 8'h05;
        repeat (5) begin
            @(posedge PCLK); #1;
            if (PREADY) readyCnt++;
        end
        checkOutput("noSetupNoReady", readyCnt, 0);
        idle(2);

        applyZeroWait(1'b1, 8'h03, 8'h77, 8'h00);
        applyZeroWait(1'b0, 8'h03, 8'h00, 8'h77);

        idle(3);
        checkOutput("scoreboardEmpty", sbQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
